shift_seq_ctrl: RTL and testbench

//  Command sequencer for a WIDTH-bit bidirectional shift register.

---
 rtl/shift_seq_ctrl_pkg.sv | 22 ++
 rtl/shift_seq_ctrl_core.sv | 29 ++
 rtl/shift_seq_ctrl.sv | 99 +++++++++
 tb/tb_shift_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift sequencer: FSM states, shift direction and
// datapath op codes.
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

  localparam logic DirLeft  = 1'b1;
  localparam logic DirRight = 1'b0;

  typedef enum logic [2:0] {
    OpHold = 3'd0,
    OpLoad = 3'd1,
    OpShl  = 3'd2,
    OpShr  = 3'd3,
    OpClr  = 3'd4
  } op_e;

endpackage

// File: rtl/shift_seq_ctrl_core.sv
// Bidirectional shift register datapath: hold/load/shift-left/shift-right/clear
// selected by the controller, with an externally chosen fill bit.
module shift_seq_ctrl_core
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  op_e              op,
  input  logic [WIDTH-1:0] load_val,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    case (op)
      OpLoad:  q_q <= load_val;
      OpShl:   q_q <= {q_q[WIDTH-2:0], fill};
      OpShr:   q_q <= {fill, q_q[WIDTH-1:1]};
      OpClr:   q_q <= '0;
      default: q_q <= q_q;
    endcase
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: loads a word, performs cnt single-bit shifts in the latched
// direction (rotate or serial fill), then pulses done for one cycle.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rdy,
  input  logic             dir,
  input  logic [CNTW-1:0]  cnt,
  input  logic             rot,
  input  logic [WIDTH-1:0] inp,
  input  logic             sin,
  input  logic             abort,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  state_e          state_q;
  logic            dir_q;
  logic            rot_q;
  logic [CNTW-1:0] rem_q;
  op_e             op;
  logic            fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= DirRight;
      rot_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            dir_q   <= dir;
            rot_q   <= rot;
            rem_q   <= cnt;
            state_q <= (cnt != '0) ? StShift : StFin;
          end
        end
        StShift: begin
          // rem_q is always >= 1 here, so the decrement cannot wrap.
          if (abort) begin
            state_q <= StIdle;
          end else begin
            rem_q <= rem_q - CNTW'(1);
            if (rem_q == CNTW'(1)) state_q <= StFin;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    op = OpHold;
    if (rst) begin
      op = OpClr;
    end else begin
      case (state_q)
        StIdle: begin
          if (start)    op = OpLoad;
          else if (clr) op = OpClr;
        end
        StShift: begin
          if (!abort) op = (dir_q == DirLeft) ? OpShl : OpShr;
        end
        default: op = OpHold;
      endcase
    end
  end

  assign sout = (dir_q == DirLeft) ? dout[WIDTH-1] : dout[0];
  assign fill = rot_q ? sout : sin;

  assign rdy  = (state_q == StIdle) && !rst;
  assign busy = (state_q == StShift) && !rst;
  assign done = (state_q == StFin) && !rst;

  shift_seq_ctrl_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .op       (op),
    .load_val (inp),
    .fill     (fill),
    .q        (dout)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus randomized
// commands against a word-level reference model.
module tb_shift_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst, start, dir, rot, sin, abort, clr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  inp;
  logic          rdy, busy, done, sout;
  logic [W-1:0]  dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(
    .WIDTH(W),
    .CNTW (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rdy   (rdy),
    .dir   (dir),
    .cnt   (cnt),
    .rot   (rot),
    .inp   (inp),
    .sin   (sin),
    .abort (abort),
    .clr   (clr),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .sout  (sout)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] shift_word(input logic [W-1:0] w, input logic left,
                                              input logic f);
    logic [W-1:0] r;
    if (left) r = (w << 1) | W'(f);
    else      r = (w >> 1) | (W'(f) << (W - 1));
    return r;
  endfunction

  function automatic logic model_sout(input logic [W-1:0] w, input logic left);
    logic [W-1:0] t;
    t = left ? (w >> (W - 1)) : w;
    return t[0];
  endfunction

  // Issues one command from IDLE and checks every cycle until back in IDLE.
  task automatic run_cmd(input logic [W-1:0] i_w, input logic i_dir, input logic [CW-1:0] i_cnt,
                         input logic i_rot, input int abort_at, input bit rand_sin,
                         input logic i_clr);
    logic [W-1:0] w;
    logic         f;
    check_eq("rdy_idle", 32'(rdy), 1);
    start = 1'b1;
    inp   = i_w;
    dir   = i_dir;
    cnt   = i_cnt;
    rot   = i_rot;
    clr   = i_clr;
    abort = 1'($urandom);
    sin   = rand_sin ? 1'($urandom) : 1'b0;
    w     = i_w;
    step();
    start = 1'b0;
    clr   = 1'b0;
    abort = 1'b0;
    inp   = W'($urandom);
    for (int i = 0; i < int'(i_cnt); i++) begin
      check_eq("busy_shift", 32'(busy), 1);
      check_eq("done_early", 32'(done), 0);
      check_eq("rdy_shift", 32'(rdy), 0);
      check_eq("dout_shift", 32'(dout), 32'(w));
      check_eq("sout_shift", 32'(sout), 32'(model_sout(w, i_dir)));
      if (i == abort_at) begin
        start = 1'b0;
        clr   = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_rdy", 32'(rdy), 1);
        check_eq("abort_dout", 32'(dout), 32'(w));
        return;
      end
      sin   = rand_sin ? 1'($urandom) : 1'b0;
      start = 1'($urandom);
      clr   = 1'($urandom);
      f     = i_rot ? model_sout(w, i_dir) : sin;
      w     = shift_word(w, i_dir, f);
      step();
    end
    check_eq("fin_done", 32'(done), 1);
    check_eq("fin_busy", 32'(busy), 0);
    check_eq("fin_rdy", 32'(rdy), 0);
    check_eq("fin_dout", 32'(dout), 32'(w));
    check_eq("fin_sout", 32'(sout), 32'(model_sout(w, i_dir)));
    start = 1'($urandom);
    clr   = 1'b0;
    inp   = W'($urandom);
    step();
    start = 1'b0;
    check_eq("post_done", 32'(done), 0);
    check_eq("post_rdy", 32'(rdy), 1);
    check_eq("post_dout", 32'(dout), 32'(w));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    dir   = 1'b0;
    rot   = 1'b0;
    sin   = 1'b0;
    abort = 1'b0;
    clr   = 1'b0;
    cnt   = '0;
    inp   = '0;

    step();
    step();
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rdy", 32'(rdy), 0);
    rst = 1'b0;
    #1;
    check_eq("rdy_after_rst", 32'(rdy), 1);

    // Left shift by 2, fill 0.
    run_cmd(4'b1011, 1'b1, 3'd2, 1'b0, -1, 1'b0, 1'b0);
    check_eq("t2_dout", 32'(dout), 32'b1100);

    // Right rotate by 1.
    run_cmd(4'b1001, 1'b0, 3'd1, 1'b1, -1, 1'b0, 1'b0);
    check_eq("t3_dout", 32'(dout), 32'b1100);
    check_eq("t3_sout", 32'(sout), 0);

    // Zero-count command: straight to done.
    run_cmd(4'b0110, 1'b1, 3'd0, 1'b0, -1, 1'b0, 1'b0);
    check_eq("t4_dout", 32'(dout), 32'b0110);

    // Abort after three left shifts with zero fill.
    run_cmd(4'b1101, 1'b1, 3'd7, 1'b0, 3, 1'b0, 1'b0);
    check_eq("t5_dout", 32'(dout), 32'b1000);

    // Clear in IDLE.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_idle", 32'(dout), 0);

    // Start wins over clear.
    run_cmd(4'b0101, 1'b0, 3'd0, 1'b0, -1, 1'b0, 1'b1);
    check_eq("clr_start_dout", 32'(dout), 32'b0101);

    // Reset in the middle of a long command.
    start = 1'b1;
    inp   = 4'b1111;
    dir   = 1'b1;
    cnt   = 3'd7;
    rot   = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    check_eq("mid_rst_dout", 32'(dout), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_done", 32'(done), 0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rdy", 32'(rdy), 1);
    step();
    check_eq("mid_rst_no_done", 32'(done), 0);
    check_eq("mid_rst_idle", 32'(rdy), 1);

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      logic [CW-1:0] c;
      int            ab;
      c  = CW'($urandom);
      ab = -1;
      if (c != '0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, int'(c) - 1));
      run_cmd(W'($urandom), 1'($urandom), c, 1'($urandom), ab, 1'b1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
